// File: rtl/q_serializer.sv
// Charge-to-pulse-train serializer: one HIGH/LOW pulse per Q_PER_PULSE charge units, then a watchdog-length quiet gap.
// q_serialized is registered (high the cycle after launch); start is edge-detected, ignored while busy; macro Q_SERIALIZER_ROUND_EN adds round-half-up.
module q_serializer #(
  parameter int BUS_WIDTH     = 10,
  parameter int Q_PER_PULSE   = 30,
  parameter int WTD_BUS_WIDTH = 3,
  parameter int HIGH_CYCLES   = 3,
  parameter int LOW_CYCLES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] q_in,
  output logic                 q_serialized,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] pulse_count,
  output logic [BUS_WIDTH-1:0] residue
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  localparam int GAP_CYCLES = 2 ** WTD_BUS_WIDTH;
  localparam int MAX_HL     = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int MAX_CYC    = (MAX_HL > GAP_CYCLES) ? MAX_HL : GAP_CYCLES;
  localparam int CW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0]        HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]        LOW_LAST  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0]        GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] QPP       = BUS_WIDTH'(Q_PER_PULSE);
`ifdef Q_SERIALIZER_ROUND_EN
  localparam logic [BUS_WIDTH-1:0] HALF      = BUS_WIDTH'((Q_PER_PULSE + 1) / 2);
`endif

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BUS_WIDTH-1:0] rem_q, rem_n, rem_eff;
  logic [BUS_WIDTH-1:0] pc_n, res_n;
  logic                 start_d;
  logic                 launch, decide, done_n;
`ifdef Q_SERIALIZER_ROUND_EN
  logic                 rounded_q, rounded_n;
`endif

  assign launch = start && !start_d && (state_q == IDLE);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 1'b1;
    rem_n   = rem_q;
    rem_eff = rem_q;
    pc_n    = pulse_count;
    res_n   = residue;
    done_n  = 1'b0;
    decide  = 1'b0;
`ifdef Q_SERIALIZER_ROUND_EN
    rounded_n = rounded_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (launch) begin
          decide  = 1'b1;
          rem_eff = q_in;
          pc_n    = '0;
`ifdef Q_SERIALIZER_ROUND_EN
          rounded_n = 1'b0;
`endif
        end
      end
      HIGH: if (cnt_q == HIGH_LAST) begin
        state_n = LOW;
        cnt_n   = '0;
      end
      LOW:  if (cnt_q == LOW_LAST) decide = 1'b1;
      GAP:  if (cnt_q == GAP_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Subtract-and-pulse step; the else branch is the zero-length TAIL decision.
    if (decide) begin
      cnt_n = '0;
      if (rem_eff >= QPP) begin
        state_n = HIGH;
        rem_n   = rem_eff - QPP;
        pc_n    = pc_n + BUS_WIDTH'(1);
      end else begin
        state_n = GAP;
        rem_n   = rem_eff;
        res_n   = rem_eff;
`ifdef Q_SERIALIZER_ROUND_EN
        if (!rounded_n && rem_eff >= HALF) begin
          state_n   = HIGH;
          pc_n      = pc_n + BUS_WIDTH'(1);
          rounded_n = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      pulse_count  <= '0;
      residue      <= '0;
      start_d      <= 1'b0;
      q_serialized <= 1'b0;
      done         <= 1'b0;
`ifdef Q_SERIALIZER_ROUND_EN
      rounded_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      rem_q        <= rem_n;
      pulse_count  <= pc_n;
      residue      <= res_n;
      start_d      <= start;
      q_serialized <= (state_n == HIGH);
      done         <= done_n;
`ifdef Q_SERIALIZER_ROUND_EN
      rounded_q    <= rounded_n;
`endif
    end
  end

endmodule

// File: doc/q_serializer.md
# q_serializer

Charge-to-pulse-train serializer: the transmit end of the `q_serialized` line. It takes a parallel charge value and emits one fixed-width pulse per `Q_PER_PULSE` charge units. It then holds the line quiet long enough for the receiving `q_measurement` watchdog to expire and close its measurement. It drives the `q_serialized` input of `q_measurement` in loopback benches and in the charge front-end model.

## Interface
- `BUS_WIDTH`, 10: width of `q_in`, `pulse_count` and `residue`.
- `Q_PER_PULSE`, 30: charge units represented by one pulse; must be ≥1 and < 2^BUS_WIDTH.
- `WTD_BUS_WIDTH`, 3: receiver watchdog width; the trailing quiet gap is 2^WTD_BUS_WIDTH cycles.
- `HIGH_CYCLES`, 3: cycles `q_serialized` is high per pulse; must be ≥1.
- `LOW_CYCLES`, 3: cycles `q_serialized` is low after each pulse; must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch request, rising-edge detected.
- `q_in`  in  BUS_WIDTH: charge to serialize, sampled at launch.
- `q_serialized`  out  1: pulse train, registered.
- `busy`  out  1: transaction in progress.
- `done`  out  1: one-cycle completion strobe.
- `pulse_count`  out  BUS_WIDTH: pulses emitted in the last transaction.
- `residue`  out  BUS_WIDTH: `q_in mod Q_PER_PULSE` of the last transaction.

## Operation
- Reset (async, `rst_n`=0):
  - State IDLE.
  - `q_serialized`, `busy`, `done`, `pulse_count`, `residue` and `start_d` all 0.
- Launch edge: the `clk` edge where `start`=1, `start_d`=0 and state=IDLE.
  - Any other `start` activity is ignored, including `start` high during busy.
  - `start` held high across a transaction does not relaunch; it must fall and rise again.
- Division uses no divider; it is done by sequential subtraction on register `rem`.
- At the launch edge:
  - Load `rem`=`q_in`; clear `pulse_count`.
  - If `q_in` ≥ `Q_PER_PULSE`: go to HIGH, `rem` -= `Q_PER_PULSE`, `pulse_count`+=1.
  - Otherwise go to TAIL.
- States and transitions:
  - IDLE: `busy`=0. On a launch edge, take the launch transition above.
  - HIGH: `q_serialized`=1 for `HIGH_CYCLES` cycles, then go to LOW.
  - LOW: `q_serialized`=0 for `LOW_CYCLES` cycles. Then, if `rem` ≥ `Q_PER_PULSE`: go to HIGH, `rem` -= `Q_PER_PULSE`, `pulse_count`+=1. Otherwise go to TAIL.
  - TAIL: latch `residue`=`rem`. Rounding decision applies here (see Configuration); it lasts 0 cycles and resolves to HIGH or GAP at the same edge.
  - GAP: `q_serialized`=0 for 2^WTD_BUS_WIDTH cycles, then go to IDLE with `done`=1 for one cycle.
- `busy`=1 in every non-IDLE state, asserted from the launch edge. `busy` and `done` are never both 1.
- Zero-charge transaction: `q_in`=0 produces no pulses, only the GAP, then `done`.
- `pulse_count` and `residue` hold their values until the next launch edge.
- Reset mid-transaction:
  - `q_serialized` falls immediately (asynchronously).
  - No `done` is issued.
  - Partial results are cleared.

## Timing
- `q_serialized` is high in the cycle following the launch edge (registered output, 1-cycle latency).
- For N emitted pulses and gap G = 2^WTD_BUS_WIDTH:
  - `done` rises N·(HIGH_CYCLES+LOW_CYCLES)+G cycles after the launch edge.
  - Defaults with N=6: 6·6+8 = 44.
- Pulse period is HIGH_CYCLES+LOW_CYCLES cycles exactly, with no stretch between pulses.
- Earliest possible next launch: the edge after `done` (requires `start` low during the `done` cycle).

## Configuration
- `Q_SERIALIZER_ROUND_EN` defined:
  - At TAIL, if `rem` ≥ (`Q_PER_PULSE`+1)/2 (integer division; 15 for default), emit one additional pulse: HIGH, `pulse_count`+=1, then GAP directly after its LOW phase.
  - `residue` still reports the floor remainder.
- Undefined: TAIL always goes to GAP (floor behaviour), and no rounding logic is compiled.

## Test plan
- Reset: assert `rst_n`=0 with `start`=1 and `q_in`=300 → all outputs 0; after release, no launch until `start` toggles low→high.
- `q_in`=180, defaults → 6 pulses of 3 high/3 low cycles; `done` 44 cycles after launch; `pulse_count`=6, `residue`=0.
- `q_in`=95 → 3 pulses; `done` at 26 cycles; `residue`=5. Same with `Q_SERIALIZER_ROUND_EN`, since 5<15.
- `q_in`=20 → without macro: 0 pulses, `done` at 8 cycles, `residue`=20. With macro: 1 pulse, `done` at 14 cycles, `pulse_count`=1.
- Second `start` rising edge at cycle 10 of a 180-charge run → ignored, `done` still at 44. Relaunch on the edge after `done` → accepted.
- `rst_n` low during the 3rd pulse's HIGH → `q_serialized`=0 and `busy`=0 within the same timestep, no `done`. Loopback into `q_measurement` with `q_in`=180 → `q_measured`=180.
